// File: rtl/usb_out_arb_pkg.sv
// Shared types and default sizing for the EZ-USB output-path arbiter.
package usb_out_arb_pkg;

  // Default maximum 32-bit words per grant and WAIT idle tolerance.
  localparam int MAX_WORDS_DEF    = 256;
  localparam int WAIT_TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_LO,
    ST_SEND_HI,
    ST_WAIT,
    ST_PKTEND
  } state_e;

endpackage

// File: rtl/usb_out_arb_rr.sv
// Two-way round-robin selector used on packet boundaries.
module usb_out_arb_rr (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic any
);

  // A lone requester always wins; on contention the one not served last time wins.
  always_comb begin
    any = valid0 | valid1;
    if (valid0 && valid1) begin
      grant = ~last_grant;
    end else begin
      grant = valid1;
    end
  end

endmodule

// File: rtl/usb_out_arbiter.sv
// Packet-level arbiter that serializes two 32-bit word streams onto the
// 16-bit ezusb_io output handshake and closes flagged packets with PKTEND.
module usb_out_arbiter
  import usb_out_arb_pkg::*;
#(
  parameter int MAX_WORDS    = MAX_WORDS_DEF,
  parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
  input  logic        ifclk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] rq0_data,
  input  logic        rq0_last,
  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic [31:0] rq1_data,
  input  logic        rq1_last,
  input  logic        rq1_valid,
  output logic        rq1_ready,
  output logic [15:0] DI,
  output logic        DI_valid,
  input  logic        DI_ready,
  output logic        pktend_arm,
  input  logic        pktend_n,
  output logic        grant,
  output logic        busy,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int TMR_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WORDS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WAIT_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [31:0]        buf_q, buf_d;
  logic               buf_last_q, buf_last_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [TMR_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [15:0]        pkt_cnt0_q, pkt_cnt0_d;
  logic [15:0]        pkt_cnt1_q, pkt_cnt1_d;
  logic               timeout_err_q, timeout_err_d;

  logic               rr_grant;
  logic               rr_any;
  logic               take_word;
  logic               take_sel;
  logic [31:0]        take_data;
  logic               take_last;
  logic               gnt_valid;

  usb_out_arb_rr u_rr (
    .valid0     (rq0_valid),
    .valid1     (rq1_valid),
    .last_grant (last_grant_q),
    .grant      (rr_grant),
    .any        (rr_any)
  );

  // Decide whether a word is captured this cycle and from which requester.
  always_comb begin
    take_word = 1'b0;
    take_sel  = grant_q;
    gnt_valid = grant_q ? rq1_valid : rq0_valid;
    case (state_q)
      ST_IDLE: begin
        if (enable && rr_any) begin
          take_word = 1'b1;
          take_sel  = rr_grant;
        end
      end
      ST_SEND_HI: begin
        if (DI_ready && !buf_last_q && (word_cnt_q != CNT_MAX) && gnt_valid) begin
          take_word = 1'b1;
        end
      end
      ST_WAIT: begin
        if (gnt_valid) begin
          take_word = 1'b1;
        end
      end
      default: begin
        take_word = 1'b0;
      end
    endcase
    take_data = take_sel ? rq1_data : rq0_data;
    take_last = take_sel ? rq1_last : rq0_last;
  end

  // Next-state, word buffer and bookkeeping counters.
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    buf_last_d    = buf_last_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    word_cnt_d    = word_cnt_q;
    pkt_cnt0_d    = pkt_cnt0_q;
    pkt_cnt1_d    = pkt_cnt1_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        if (take_word) begin
          state_d      = ST_SEND_LO;
          grant_d      = take_sel;
          last_grant_d = take_sel;
          word_cnt_d   = CNT_W'(1);
        end
      end
      ST_SEND_LO: begin
        if (DI_ready) begin
          state_d = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (DI_ready) begin
          if (buf_last_q) begin
            state_d = ST_PKTEND;
            if (grant_q) begin
              pkt_cnt1_d = pkt_cnt1_q + 16'd1;
            end else begin
              pkt_cnt0_d = pkt_cnt0_q + 16'd1;
            end
          end else if (word_cnt_q == CNT_MAX) begin
            state_d = ST_IDLE;
          end else if (take_word) begin
            state_d    = ST_SEND_LO;
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (take_word) begin
          state_d    = ST_SEND_LO;
          word_cnt_d = word_cnt_q + CNT_W'(1);
        end else if (wait_cnt_q == TMR_LAST) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end
      end
      ST_PKTEND: begin
        if (!pktend_n) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (take_word) begin
      buf_d      = take_data;
      buf_last_d = take_last;
    end
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      wait_cnt_d = wait_cnt_q + TMR_W'(1);
    end else begin
      wait_cnt_d = '0;
    end
  end

  // Outputs depend only on registered state, except ready which follows the capture decision.
  always_comb begin
    DI         = 16'h0000;
    DI_valid   = 1'b0;
    pktend_arm = 1'b0;
    case (state_q)
      ST_SEND_LO: begin
        DI       = buf_q[15:0];
        DI_valid = 1'b1;
      end
      ST_SEND_HI: begin
        DI       = buf_q[31:16];
        DI_valid = 1'b1;
      end
      ST_PKTEND: begin
        pktend_arm = 1'b1;
      end
      default: begin
        DI_valid = 1'b0;
      end
    endcase
    rq0_ready   = take_word && !take_sel;
    rq1_ready   = take_word && take_sel;
    busy        = (state_q != ST_IDLE);
    grant       = grant_q;
    pkt_cnt0    = pkt_cnt0_q;
    pkt_cnt1    = pkt_cnt1_q;
    timeout_err = timeout_err_q;
  end

  // State register; reset discards any held word without issuing PKTEND.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      buf_q         <= '0;
      buf_last_q    <= 1'b0;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      word_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      pkt_cnt0_q    <= '0;
      pkt_cnt1_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      buf_last_q    <= buf_last_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      word_cnt_q    <= word_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      pkt_cnt0_q    <= pkt_cnt0_d;
      pkt_cnt1_q    <= pkt_cnt1_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule
